// File: rtl/glb_pkg.sv
// Shared constants, state encoding and length check for the GLB sequencer.
package glb_pkg;

    localparam int GLB_DEPTH  = 64;
    localparam int GLB_ADDR_W = 6;
    localparam int LEN_W      = 7;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAIN
    } state_t;

    // A start is honoured only for 1..GLB_DEPTH words.
    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(GLB_DEPTH));
    endfunction

endpackage

// File: rtl/glb_out_fifo.sv
// Small synchronous FIFO that absorbs GLB read latency against PE back-pressure.
module glb_out_fifo #(
    parameter  int num_bits   = 16,
    parameter  int fifo_depth = 4,
    localparam int PTR_W      = $clog2(fifo_depth),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                w_clk,
    input  logic                w_rst,
    input  logic                w_push,
    input  logic [num_bits-1:0] w_push_data,
    input  logic                w_pop,
    output logic [num_bits-1:0] r_head,
    output logic [CNT_W-1:0]    r_count
);

    logic [num_bits-1:0] mem [fifo_depth];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    // Storage is data only and carries no reset.
    always_ff @(posedge w_clk) begin
        if (w_push) begin
            mem[wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign r_head = mem[rd_ptr];

endmodule

// File: rtl/glb_ctrl.sv
// LOAD/DRAIN/CLEAR sequencer in front of the single-PE GLB, with a read-ahead output FIFO.
module glb_ctrl
    import glb_pkg::*;
#(
    parameter int num_bits   = 16,
    parameter int fifo_depth = 4
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  w_clear,
    input  logic                  w_load_start,
    input  logic                  w_drain_start,
    input  logic [LEN_W-1:0]      w_len,
    input  logic                  w_in_valid,
    input  logic [num_bits-1:0]   w_in_data,
    output logic                  r_in_ready,
    output logic                  r_out_valid,
    output logic [num_bits-1:0]   r_out_data,
    input  logic                  w_out_ready,
    output logic                  r_busy,
    output logic                  r_done,
    output logic                  r_glb_ready,
    output logic                  r_glb_rw,
    output logic [GLB_ADDR_W-1:0] r_glb_address,
    output logic [num_bits-1:0]   r_glb_data,
    input  logic [num_bits-1:0]   w_glb_data
);

    localparam int CNT_W = $clog2(fifo_depth) + 1;
    localparam int OCC_W = CNT_W + 1;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] load_cnt;
    logic [LEN_W-1:0] issue_cnt;
    logic [LEN_W-1:0] deliver_cnt;
    logic             rd_vld_p0;
    logic             rd_vld_p1;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occupancy;
    logic             issue_ok;
    logic             fifo_pop;

    // Reads in flight (address on the bus, data on the bus) reserve FIFO slots before they land.
    assign occupancy   = OCC_W'(fifo_count) + OCC_W'(rd_vld_p0) + OCC_W'(rd_vld_p1);
    assign issue_ok    = (occupancy < OCC_W'(fifo_depth)) && (issue_cnt < len_q);
    assign r_out_valid = (fifo_count != '0);
    assign fifo_pop    = r_out_valid && w_out_ready;

    glb_out_fifo #(
        .num_bits   (num_bits),
        .fifo_depth (fifo_depth)
    ) u_fifo (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_push      (rd_vld_p1),
        .w_push_data (w_glb_data),
        .w_pop       (fifo_pop),
        .r_head      (r_out_data),
        .r_count     (fifo_count)
    );

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state         <= IDLE;
            len_q         <= '0;
            load_cnt      <= '0;
            issue_cnt     <= '0;
            deliver_cnt   <= '0;
            rd_vld_p0     <= 1'b0;
            rd_vld_p1     <= 1'b0;
            r_in_ready    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_glb_ready   <= 1'b0;
            r_glb_rw      <= 1'b0;
            r_glb_address <= '0;
            r_glb_data    <= '0;
        end else begin
            r_done    <= 1'b0;
            rd_vld_p0 <= 1'b0;
            // p0 -> p1: address presented this cycle, GLB data valid next cycle
            rd_vld_p1 <= rd_vld_p0;
            case (state)
                IDLE: begin
                    r_glb_ready <= 1'b1;
                    r_glb_rw    <= 1'b0;
                    r_in_ready  <= 1'b0;
                    if (w_clear) begin
                        state       <= CLEAR;
                        r_busy      <= 1'b1;
                        r_glb_ready <= 1'b0;
                    end else if (w_load_start && len_ok(w_len)) begin
                        state      <= LOAD;
                        len_q      <= w_len;
                        load_cnt   <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (w_drain_start && len_ok(w_len)) begin
                        state       <= DRAIN;
                        len_q       <= w_len;
                        issue_cnt   <= '0;
                        deliver_cnt <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_glb_ready <= 1'b1;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    state       <= IDLE;
                end
                LOAD: begin
                    if (w_in_valid && r_in_ready) begin
                        r_glb_rw      <= 1'b1;
                        r_glb_address <= load_cnt[GLB_ADDR_W-1:0];
                        r_glb_data    <= w_in_data;
                        load_cnt      <= load_cnt + LEN_W'(1);
                        if (load_cnt == len_q - LEN_W'(1)) begin
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        r_glb_rw <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_glb_rw <= 1'b0;
                    if (issue_ok) begin
                        r_glb_address <= issue_cnt[GLB_ADDR_W-1:0];
                        rd_vld_p0     <= 1'b1;
                        issue_cnt     <= issue_cnt + LEN_W'(1);
                    end
                    if (fifo_pop) begin
                        deliver_cnt <= deliver_cnt + LEN_W'(1);
                        if (deliver_cnt == len_q - LEN_W'(1)) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glb_ctrl.sv
// Randomized bench for glb_ctrl driving a behavioural GLB; checks against a word-level memory model.
module tb_glb_ctrl;

    logic        clk = 1'b0;
    logic        w_rst = 1'b1;
    logic        w_clear = 1'b0;
    logic        w_load_start = 1'b0;
    logic        w_drain_start = 1'b0;
    logic [6:0]  w_len = '0;
    logic        w_in_valid = 1'b0;
    logic [15:0] w_in_data = '0;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic        w_out_ready = 1'b0;
    logic        r_busy;
    logic        r_done;
    logic        r_glb_ready;
    logic        r_glb_rw;
    logic [5:0]  r_glb_address;
    logic [15:0] r_glb_data;
    logic [15:0] w_glb_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [15:0] glb_mem [64];
    logic [15:0] ref_mem [64];
    logic [15:0] stim    [64];

    always #5 clk = ~clk;

    glb_ctrl #(.num_bits(16), .fifo_depth(4)) dut (
        .w_clk         (clk),
        .w_rst         (w_rst),
        .w_clear       (w_clear),
        .w_load_start  (w_load_start),
        .w_drain_start (w_drain_start),
        .w_len         (w_len),
        .w_in_valid    (w_in_valid),
        .w_in_data     (w_in_data),
        .r_in_ready    (r_in_ready),
        .r_out_valid   (r_out_valid),
        .r_out_data    (r_out_data),
        .w_out_ready   (w_out_ready),
        .r_busy        (r_busy),
        .r_done        (r_done),
        .r_glb_ready   (r_glb_ready),
        .r_glb_rw      (r_glb_rw),
        .r_glb_address (r_glb_address),
        .r_glb_data    (r_glb_data),
        .w_glb_data    (w_glb_data)
    );

    // Behavioural GLB: clears while ready is low, writes on rw=1, registered read on rw=0.
    always @(posedge clk) begin
        if (!r_glb_ready) begin
            for (int i = 0; i < 64; i++) glb_mem[i] <= '0;
        end else if (r_glb_rw) begin
            glb_mem[r_glb_address] <= r_glb_data;
        end else begin
            w_glb_data <= glb_mem[r_glb_address];
        end
    end

    always @(negedge clk) if (r_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    endtask

    task automatic do_load(input int len, input int gap_pct);
        int sent;
        int cyc;
        int d0;
        int bad;
        d0 = done_cnt;
        w_len = 7'(len);
        w_load_start = 1'b1;
        tick();
        w_load_start = 1'b0;
        sent = 0;
        cyc = 0;
        while (sent < len && cyc < 2000) begin
            w_in_valid = (int'($urandom_range(99)) >= gap_pct);
            w_in_data  = stim[sent];
            if (w_in_valid && r_in_ready) begin
                ref_mem[sent] = stim[sent];
                sent++;
            end
            tick();
            cyc++;
        end
        w_in_valid = 1'b0;
        check("load_beats", 32'(sent), 32'(len));
        if (gap_pct == 0) check("load_b2b_cycles", 32'(cyc), 32'(len));
        check("load_ready_drop", 32'(r_in_ready), 32'd0);
        check("load_last_rw", 32'(r_glb_rw), 32'd1);
        check("load_last_addr", 32'(r_glb_address), 32'(len - 1));
        check("load_last_data", 32'(r_glb_data), 32'(stim[len - 1]));
        check("load_done_now", 32'(r_done), 32'd1);
        tick();
        check("load_done_once", 32'(done_cnt - d0), 32'd1);
        check("load_busy_off", 32'(r_busy), 32'd0);
        bad = 0;
        for (int i = 0; i < len; i++) if (glb_mem[i] !== ref_mem[i]) bad++;
        check("load_glb_contents", 32'(bad), 32'd0);
    endtask

    // mode 0: always ready; 1: five-cycle stall after two words; 2: random ready
    task automatic do_drain(input int len, input int mode);
        int got;
        int cyc;
        int first_v;
        int first_hs;
        int last_hs;
        int stalled;
        int max_addr;
        bit prev_stall;
        logic [15:0] prev_data;
        w_len = 7'(len);
        w_drain_start = 1'b1;
        tick();
        w_drain_start = 1'b0;
        got = 0; cyc = 0; first_v = -1; first_hs = 0; last_hs = 0;
        stalled = 0; max_addr = 0; prev_stall = 1'b0; prev_data = '0;
        while (got < len && cyc < 2000) begin
            if (mode == 1 && got == 2 && stalled < 5) begin
                w_out_ready = 1'b0;
                stalled++;
            end else if (mode == 2) begin
                w_out_ready = ($urandom_range(99) < 60);
            end else begin
                w_out_ready = 1'b1;
            end
            if (cyc >= 1 && r_busy && !r_glb_rw && int'(r_glb_address) > max_addr)
                max_addr = int'(r_glb_address);
            if (r_out_valid && first_v < 0) first_v = cyc;
            if (prev_stall) check("drain_hold_stable", 32'(r_out_data), 32'(prev_data));
            prev_stall = r_out_valid && !w_out_ready;
            prev_data  = r_out_data;
            if (r_out_valid && w_out_ready) begin
                check($sformatf("drain_word%0d", got), 32'(r_out_data), 32'(ref_mem[got]));
                if (got == 0) first_hs = cyc;
                last_hs = cyc;
                got++;
            end
            tick();
            cyc++;
        end
        w_out_ready = 1'b0;
        check("drain_count", 32'(got), 32'(len));
        check("drain_max_addr", 32'(max_addr), 32'(len - 1));
        if (mode == 0) begin
            check("drain_first_valid", 32'(first_v), 32'd3);
            check("drain_rate", 32'(last_hs - first_hs), 32'(len - 1));
        end
        check("drain_done_pulse", 32'(r_done), 32'd1);
        check("drain_busy_off", 32'(r_busy), 32'd0);
        check("drain_valid_off", 32'(r_out_valid), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        model_clear();
        // Reset
        tick();
        tick();
        check("rst_glb_ready", 32'(r_glb_ready), 32'd0);
        check("rst_in_ready", 32'(r_in_ready), 32'd0);
        check("rst_out_valid", 32'(r_out_valid), 32'd0);
        check("rst_busy", 32'(r_busy), 32'd0);
        check("rst_glb_rw", 32'(r_glb_rw), 32'd0);
        w_rst = 1'b0;
        tick();
        check("rst_release_ready", 32'(r_glb_ready), 32'd1);

        // Directed 4-word load and drains
        stim[0] = 16'h0011; stim[1] = 16'h0022; stim[2] = 16'h0033; stim[3] = 16'h0044;
        do_load(4, 0);
        for (int i = 0; i < 4; i++) check($sformatf("glb_addr%0d", i), 32'(glb_mem[i]), 32'(stim[i]));
        do_drain(4, 0);
        do_drain(4, 1);

        // Full-depth load of index values
        for (int i = 0; i < 64; i++) stim[i] = 16'(i);
        do_load(64, 0);
        do_drain(64, 0);

        // Illegal lengths are ignored
        w_len = 7'd0; w_load_start = 1'b1;
        tick();
        w_load_start = 1'b0;
        check("len0_ignored", 32'(r_busy), 32'd0);
        w_len = 7'd65; w_drain_start = 1'b1;
        tick();
        w_drain_start = 1'b0;
        check("len65_ignored", 32'(r_busy), 32'd0);

        // Randomized rounds
        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(64, 1));
            for (int i = 0; i < 64; i++) stim[i] = 16'($urandom);
            do_load(len, 30);
            do_drain(len, 2);
        end

        // Clear command
        w_clear = 1'b1;
        tick();
        w_clear = 1'b0;
        check("clear_ready_low", 32'(r_glb_ready), 32'd0);
        check("clear_busy", 32'(r_busy), 32'd1);
        model_clear();
        tick();
        check("clear_ready_back", 32'(r_glb_ready), 32'd1);
        check("clear_done", 32'(r_done), 32'd1);
        do_drain(8, 2);

        // Reset in the middle of a drain
        for (int i = 0; i < 64; i++) stim[i] = 16'($urandom) | 16'h0001;
        do_load(64, 0);
        w_len = 7'd64; w_drain_start = 1'b1; w_out_ready = 1'b1;
        tick();
        w_drain_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
        w_out_ready = 1'b0;
        model_clear();
        check("midrst_out_valid", 32'(r_out_valid), 32'd0);
        check("midrst_busy", 32'(r_busy), 32'd0);
        check("midrst_glb_ready", 32'(r_glb_ready), 32'd0);
        tick();
        check("midrst_ready_back", 32'(r_glb_ready), 32'd1);
        do_drain(4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
